// File: rtl/game_sequencer_if.sv
// game_sequencer_if: player, random-source and cell select/fire signals of the game sequencer.
interface game_sequencer_if;
  logic [2:0] rand_in;
  logic user_fire;
  logic user_nrow;
  logic [3:0] user_row_column;
  logic user_error;
  logic mix_req;
  logic win;
  logic cell_fire;
  logic cell_nrow;
  logic [3:0] cell_row_column;
  logic scramble_active;
  logic won;
  logic [13:0] move_count;
  logic [1:0] state;
  modport master (
    output rand_in, user_fire, user_nrow, user_row_column, user_error, mix_req, win,
    input cell_fire, cell_nrow, cell_row_column, scramble_active, won, move_count, state
  );
  modport slave (
    input rand_in, user_fire, user_nrow, user_row_column, user_error, mix_req, win,
    output cell_fire, cell_nrow, cell_row_column, scramble_active, won, move_count, state
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: scrambles the 4x4 grid, hands the select/fire path to the player, counts moves and latches the win.
module game_sequencer #(
  parameter int SCRAMBLE_MOVES = 16,
  parameter int FIRE_GAP = 15,
  parameter int SETTLE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  game_sequencer_if.slave bus
);
  localparam int GW = FIRE_GAP > 1 ? $clog2(FIRE_GAP) : 1;
  localparam int IW = $clog2(SCRAMBLE_MOVES + 1);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(FIRE_GAP - 1);
  localparam logic [IW-1:0] MOVES_N = IW'(SCRAMBLE_MOVES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [13:0] MOVE_MAX = 14'd9999;
  typedef enum logic [1:0] {SCRAMBLE = 2'b00, CHECK = 2'b01, PLAY = 2'b10, WON = 2'b11} state_t;
  state_t st;
  logic [GW-1:0] gap;
  logic [IW-1:0] issued;
  logic [SW-1:0] settle;
  logic fire, nrow, won_r, active;
  logic [3:0] rc;
  logic [13:0] moves;
  logic accept;
  assign accept = bus.user_fire & ~bus.user_error;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= SCRAMBLE;
      gap <= '0;
      issued <= '0;
      settle <= '0;
      fire <= 1'b0;
      nrow <= 1'b0;
      rc <= '0;
      moves <= '0;
      won_r <= 1'b0;
      active <= 1'b1;
    end else begin
      fire <= 1'b0;
      case (st)
        SCRAMBLE: begin
          if (issued == MOVES_N) begin
            st <= CHECK;
            gap <= '0;
          end else if (gap == GAP_LAST) begin
            gap <= '0;
            issued <= issued + 1'b1;
            fire <= 1'b1;
            nrow <= bus.rand_in[2];
            rc <= 4'b0001 << bus.rand_in[1:0];
          end else begin
            gap <= gap + 1'b1;
          end
        end
        CHECK: begin
          if (settle == SETTLE_LAST) begin
            settle <= '0;
            gap <= '0;
            issued <= '0;
            st <= bus.win ? SCRAMBLE : PLAY;
            active <= bus.win;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        PLAY: begin
          if (bus.mix_req) begin
            st <= SCRAMBLE;
            moves <= '0;
            gap <= '0;
            issued <= '0;
            active <= 1'b1;
          end else if (bus.win) begin
            // a fire coinciding with the win is neither forwarded nor counted
            st <= WON;
            won_r <= 1'b1;
            rc <= '0;
          end else begin
            nrow <= bus.user_nrow;
            rc <= bus.user_error ? 4'b0000 : bus.user_row_column;
            fire <= accept;
            moves <= (accept && moves != MOVE_MAX) ? moves + 1'b1 : moves;
          end
        end
        WON: begin
          if (bus.mix_req) begin
            st <= SCRAMBLE;
            moves <= '0;
            gap <= '0;
            issued <= '0;
            won_r <= 1'b0;
            active <= 1'b1;
          end
        end
      endcase
    end
  end
  assign bus.cell_fire = fire;
  assign bus.cell_nrow = nrow;
  assign bus.cell_row_column = rc;
  assign bus.scramble_active = active;
  assign bus.won = won_r;
  assign bus.move_count = moves;
  assign bus.state = st;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenarios for game_sequencer with SCRAMBLE_MOVES=4, FIRE_GAP=3, SETTLE_CYCLES=2.
module tb_game_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  game_sequencer_if bus();
  game_sequencer #(.SCRAMBLE_MOVES(4), .FIRE_GAP(3), .SETTLE_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (bus.state !== 2'b00 || bus.cell_fire !== 1'b0 || bus.cell_nrow !== 1'b0 || bus.cell_row_column !== 4'b0000 ||
        bus.move_count !== 14'd0 || bus.won !== 1'b0 || bus.scramble_active !== 1'b1) begin
      bad++;
      $display("FAIL %s: state=%b fire=%b nrow=%b rc=%b moves=%0d won=%b active=%b, required 00 0 0 0000 0 0 1",
               tag, bus.state, bus.cell_fire, bus.cell_nrow, bus.cell_row_column, bus.move_count, bus.won, bus.scramble_active);
    end
  endtask

  task automatic test_reset();
    bus.rand_in = 3'b000;
    bus.user_fire = 1'b0;
    bus.user_nrow = 1'b0;
    bus.user_row_column = 4'b0000;
    bus.user_error = 1'b0;
    bus.mix_req = 1'b0;
    bus.win = 1'b0;
    reset = 1'b1;
    step();
    step();
    check_reset_values("reset");
    reset = 1'b0;
  endtask

  task automatic test_scramble();
    logic [2:0] rv [4] = '{3'b110, 3'b001, 3'b011, 3'b100};
    logic exp_nrow [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp_rc [4] = '{4'b0100, 4'b0010, 4'b1000, 4'b0001};
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (bus.cell_fire !== 1'b0) begin
        bad++;
        $display("FAIL scramble_gap%0d: fire=%b required 0", k, bus.cell_fire);
      end
      step();
      bus.rand_in = rv[k];
      step();
      total++;
      if (bus.cell_fire !== 1'b1 || bus.cell_nrow !== exp_nrow[k] || bus.cell_row_column !== exp_rc[k]) begin
        bad++;
        $display("FAIL scramble_fire%0d: fire=%b nrow=%b rc=%b required 1 %b %b",
                 k, bus.cell_fire, bus.cell_nrow, bus.cell_row_column, exp_nrow[k], exp_rc[k]);
      end
    end
    step();
    total++;
    if (bus.state !== 2'b01 || bus.cell_fire !== 1'b0 || bus.scramble_active !== 1'b1 || bus.cell_row_column !== 4'b0001) begin
      bad++;
      $display("FAIL enter_check: state=%b fire=%b active=%b rc=%b required 01 0 1 0001",
               bus.state, bus.cell_fire, bus.scramble_active, bus.cell_row_column);
    end
    step();
    total++;
    if (bus.state !== 2'b01) begin
      bad++;
      $display("FAIL check_hold: state=%b required 01", bus.state);
    end
    step();
    total++;
    if (bus.state !== 2'b10 || bus.scramble_active !== 1'b0) begin
      bad++;
      $display("FAIL enter_play: state=%b active=%b required 10 0", bus.state, bus.scramble_active);
    end
  endtask

  task automatic test_rescramble();
    int fires = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.win = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (bus.cell_fire === 1'b1) fires++;
    end
    total++;
    if (fires != 4) begin
      bad++;
      $display("FAIL rescramble_first: fires=%0d required 4", fires);
    end
    step();
    step();
    step();
    total++;
    if (bus.state !== 2'b00 || bus.scramble_active !== 1'b1) begin
      bad++;
      $display("FAIL rescramble_state: state=%b active=%b required 00 1", bus.state, bus.scramble_active);
    end
    bus.win = 1'b0;
    for (int e = 16; e <= 28; e++) begin
      step();
      total++;
      if (bus.cell_fire !== (((e - 15) % 3 == 0) && e <= 27)) begin
        bad++;
        $display("FAIL rescramble_edge%0d: fire=%b required %b", e, bus.cell_fire, ((e - 15) % 3 == 0) && e <= 27);
      end
    end
    total++;
    if (bus.state !== 2'b01) begin
      bad++;
      $display("FAIL rescramble_check: state=%b required 01", bus.state);
    end
    step();
    step();
    total++;
    if (bus.state !== 2'b10) begin
      bad++;
      $display("FAIL rescramble_play: state=%b required 10", bus.state);
    end
  endtask

  task automatic test_play();
    bus.user_nrow = 1'b0;
    bus.user_row_column = 4'b0010;
    bus.user_error = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.user_fire = 1'b1;
      step();
      bus.user_fire = 1'b0;
      total++;
      if (bus.cell_fire !== 1'b1 || bus.cell_row_column !== 4'b0010 || bus.cell_nrow !== 1'b0) begin
        bad++;
        $display("FAIL play_fire%0d: fire=%b rc=%b nrow=%b required 1 0010 0", i, bus.cell_fire, bus.cell_row_column, bus.cell_nrow);
      end
      step();
      total++;
      if (bus.cell_fire !== 1'b0) begin
        bad++;
        $display("FAIL play_gap%0d: fire=%b required 0", i, bus.cell_fire);
      end
    end
    bus.user_error = 1'b1;
    bus.user_fire = 1'b1;
    step();
    bus.user_fire = 1'b0;
    bus.user_error = 1'b0;
    total++;
    if (bus.cell_fire !== 1'b0 || bus.cell_row_column !== 4'b0000) begin
      bad++;
      $display("FAIL play_error: fire=%b rc=%b required 0 0000", bus.cell_fire, bus.cell_row_column);
    end
    step();
    total++;
    if (bus.move_count !== 14'd3) begin
      bad++;
      $display("FAIL play_count: moves=%0d required 3", bus.move_count);
    end
  endtask

  task automatic test_win();
    bus.user_fire = 1'b1;
    bus.win = 1'b1;
    step();
    bus.win = 1'b0;
    total++;
    if (bus.state !== 2'b11 || bus.won !== 1'b1 || bus.cell_fire !== 1'b0 || bus.move_count !== 14'd3 || bus.cell_row_column !== 4'b0000) begin
      bad++;
      $display("FAIL win_enter: state=%b won=%b fire=%b moves=%0d rc=%b required 11 1 0 3 0000",
               bus.state, bus.won, bus.cell_fire, bus.move_count, bus.cell_row_column);
    end
    step();
    bus.user_fire = 1'b0;
    total++;
    if (bus.cell_fire !== 1'b0 || bus.move_count !== 14'd3 || bus.state !== 2'b11) begin
      bad++;
      $display("FAIL win_ignore_fire: fire=%b moves=%0d state=%b required 0 3 11", bus.cell_fire, bus.move_count, bus.state);
    end
    bus.mix_req = 1'b1;
    step();
    bus.mix_req = 1'b0;
    total++;
    if (bus.state !== 2'b00 || bus.move_count !== 14'd0 || bus.won !== 1'b0 || bus.scramble_active !== 1'b1) begin
      bad++;
      $display("FAIL win_mix: state=%b moves=%0d won=%b active=%b required 00 0 0 1",
               bus.state, bus.move_count, bus.won, bus.scramble_active);
    end
  endtask

  task automatic test_saturate();
    int k = 0;
    while (bus.state !== 2'b10 && k < 100) begin
      step();
      k++;
    end
    total++;
    if (bus.state !== 2'b10) begin
      bad++;
      $display("FAIL sat_reach_play: state=%b required 10 within 100 cycles", bus.state);
    end
    bus.user_row_column = 4'b0100;
    bus.user_fire = 1'b1;
    repeat (9998) step();
    total++;
    if (bus.move_count !== 14'd9998) begin
      bad++;
      $display("FAIL sat_9998: moves=%0d required 9998", bus.move_count);
    end
    repeat (3) step();
    bus.user_fire = 1'b0;
    total++;
    if (bus.move_count !== 14'd9999) begin
      bad++;
      $display("FAIL sat_hold: moves=%0d required 9999", bus.move_count);
    end
  endtask

  task automatic test_reset_mid_scramble();
    int fires = 0;
    bus.mix_req = 1'b1;
    step();
    bus.mix_req = 1'b0;
    total++;
    if (bus.state !== 2'b00 || bus.move_count !== 14'd0) begin
      bad++;
      $display("FAIL mix_from_play: state=%b moves=%0d required 00 0", bus.state, bus.move_count);
    end
    bus.rand_in = 3'b111;
    repeat (6) step();
    total++;
    if (bus.cell_fire !== 1'b1 || bus.cell_nrow !== 1'b1 || bus.cell_row_column !== 4'b1000) begin
      bad++;
      $display("FAIL mid_second_fire: fire=%b nrow=%b rc=%b required 1 1 1000", bus.cell_fire, bus.cell_nrow, bus.cell_row_column);
    end
    reset = 1'b1;
    step();
    check_reset_values("mid_reset");
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (bus.cell_fire === 1'b1) fires++;
    end
    total++;
    if (fires != 4) begin
      bad++;
      $display("FAIL mid_restart_fires: fires=%0d required 4", fires);
    end
    step();
    total++;
    if (bus.state !== 2'b01) begin
      bad++;
      $display("FAIL mid_restart_check: state=%b required 01", bus.state);
    end
  endtask

  initial begin
    test_reset();
    test_scramble();
    test_rescramble();
    test_play();
    test_win();
    test_saturate();
    test_reset_mid_scramble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller for the 4x4 cell grid.
- On power-up and on each mix request it runs a rate-limited random scramble, issuing SCRAMBLE_MOVES fire pulses to the cells through the row/column select path.
- It then verifies the board is not already solved, hands the select/fire path to the player, counts accepted moves, and latches the win condition.
- Its outputs replace the fixed scramble_state tie-off: it drives the cell fire/nRow/row_column inputs and the move-count display source.

Parameters:
- SCRAMBLE_MOVES, 16: number of random fire pulses per scramble, >=1.
- FIRE_GAP, 15: clock cycles between consecutive scramble fires, >=1 (1 = every cycle).
- SETTLE_CYCLES, 4: cycles allowed for the win checker to settle after a scramble, >=1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rand_in  input  3  random source; [2] selects nRow, [1:0] selects the line index
- user_fire  input  1  single-cycle rising-edge pulse from the debounced fire button
- user_nrow  input  1  player selection: 0 = row, 1 = column
- user_row_column  input  4  player one-hot line select
- user_error  input  1  high when the player switch pattern is not one-hot
- mix_req  input  1  single-cycle pulse requesting a new scramble
- win  input  1  board-solved flag from the win checker
- cell_fire  output  1  fire pulse to all cells
- cell_nrow  output  1  row/column selector to the select decoder
- cell_row_column  output  4  one-hot line select to the select decoder
- scramble_active  output  1  high in SCRAMBLE and CHECK
- won  output  1  high in WON
- move_count  output  14  accepted player moves, saturating at 9999
- state  output  2  00 SCRAMBLE, 01 CHECK, 10 PLAY, 11 WON

Behaviour:
- All outputs are registered.
- Reset takes priority over everything, including mid-scramble. Reset values:
  - state = SCRAMBLE
  - gap counter = 0, issued counter = 0, settle counter = 0
  - cell_fire = 0, cell_nrow = 0, cell_row_column = 0000
  - move_count = 0, won = 0, scramble_active = 1
- SCRAMBLE:
  - Gap counter increments each cycle.
  - When it equals FIRE_GAP-1, the block clears the gap counter, increments the issued counter, and on that edge registers:
    - cell_fire = 1
    - cell_nrow = rand_in[2]
    - cell_row_column = onehot(rand_in[1:0]): 00->0001, 01->0010, 10->0100, 11->1000
  - cell_fire is high for exactly one cycle per issue.
  - cell_nrow and cell_row_column hold until the next issue.
  - The edge after the SCRAMBLE_MOVES-th fire enters CHECK.
  - user_fire and mix_req are ignored.
- CHECK:
  - cell_fire = 0; selects held; settle counter counts SETTLE_CYCLES cycles.
  - On the last cycle, win is sampled:
    - win = 1: return to SCRAMBLE with gap/issued counters cleared (re-scramble).
    - win = 0: enter PLAY.
  - Inputs other than win are ignored.
- PLAY:
  - Each cycle registers cell_nrow = user_nrow and cell_row_column = user_error ? 0000 : user_row_column (1-cycle latency).
  - cell_fire = user_fire & ~user_error, registered (1-cycle latency).
  - Each accepted fire increments move_count; at 9999 it holds.
  - Priority in the same cycle is mix_req > win > user_fire:
    - mix_req: SCRAMBLE; move_count, gap and issued counters cleared; fire dropped.
    - else win: WON; a coincident fire is dropped and not counted.
- WON:
  - won = 1, cell_fire = 0, cell_row_column = 0000, move_count frozen.
  - user_fire ignored.
  - mix_req -> SCRAMBLE; move_count and counters cleared; won drops on that edge.
- Counter widths: gap counter clog2(FIRE_GAP) bits (min 1); issued counter clog2(SCRAMBLE_MOVES+1) bits. No wrap is possible within a scramble.

Test Plan:
- SCRAMBLE_MOVES=4, FIRE_GAP=3, SETTLE_CYCLES=2, win=0; release reset; rand_in = 3'b110, 3'b001, 3'b011, 3'b100 at the issue edges -> cell_fire high one cycle after edges 3, 6, 9 and 12. Select values in order:
  - nrow=1, rc=0100
  - nrow=0, rc=0010
  - nrow=0, rc=1000
  - nrow=1, rc=0001
  Then state=01 after edge 13 and state=10 after edge 15.
- Same setup with win=1 through CHECK -> state returns to 00 after edge 15, and 4 more fires are issued at the same 3-cycle spacing.
- In PLAY: 3 user_fire pulses with user_nrow=0, user_row_column=0010, then 1 pulse with user_error=1 -> 3 cell_fire pulses each 1 cycle late, rc=0010, move_count=3; the error pulse yields no fire and rc=0000.
- In PLAY: user_fire and win in the same cycle -> state=11, won=1, no cell_fire, move_count unchanged. Later mix_req -> state=00, move_count=0, won=0.
- Force move_count to 9998 via fires, then 3 more fires -> move_count reads 9999 and stays there.
- reset asserted after the 2nd scramble fire -> next cycle all outputs at reset values; after release the scramble restarts and issues the full SCRAMBLE_MOVES fires.
